// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / interrupt sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        StRun     = 3'b000,
        StEnter   = 3'b001,
        StHandler = 3'b010,
        StDrain   = 3'b011,
        StRestore = 3'b100
    } int_state_e;

    localparam logic [31:0] INT_VECTOR_DEFAULT = 32'h0000_0100;
    localparam logic [4:0]  REG_X0             = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: the load in EX writes a register the instruction in ID reads.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic [4:0] EX_rd,
    input  logic       EX_mem_read,
    output logic       hz
);

    always_comb begin
        hz = EX_mem_read && (EX_rd != REG_X0) && ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));
    end

endmodule

// File: rtl/pipe_hazard_int_ctrl.sv
// Front-end sequencer: load-use stall, taken-branch flush and the interrupt
// entry/drain/restore FSM driving the ID/EX backup controls.
module pipe_hazard_int_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR   = INT_VECTOR_DEFAULT,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic [4:0]  EX_rd,
    input  logic        EX_mem_read,
    input  logic        EX_branch_taken,
    input  logic [31:0] IF_PC,
    input  logic        int_req,
    input  logic        int_en,
    input  logic        ID_mret,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        IF_Flush,
    output logic        ID_Flush_hazard,
    output logic        ID_Flush_branch,
    output logic        INT_detected,
    output logic        INT_restore,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        int_ack,
    output logic        in_handler,
    output logic [31:0] epc
);

    localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    int_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     epc_q, epc_d;
    logic            hz;
    logic            hz_eff;

    load_use_detect u_load_use_detect (
        .ID_rs1      (ID_rs1),
        .ID_rs2      (ID_rs2),
        .EX_rd       (EX_rd),
        .EX_mem_read (EX_mem_read),
        .hz          (hz)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;

        // The ID instruction is wrong-path under a taken branch, so its hazard is moot.
        hz_eff = hz && !EX_branch_taken;

        PC_write        = !hz_eff;
        IF_ID_write     = !hz_eff;
        IF_Flush        = EX_branch_taken;
        ID_Flush_hazard = hz_eff;
        ID_Flush_branch = EX_branch_taken;
        INT_detected    = 1'b0;
        INT_restore     = 1'b0;
        int_ack         = 1'b0;
        pc_redirect     = 1'b0;
        redirect_pc     = '0;

        unique case (state_q)
            StRun: begin
                if (int_req && int_en && !EX_branch_taken && !hz) begin
                    state_d = StEnter;
                end
            end
            StEnter: begin
                INT_detected    = 1'b1;
                int_ack         = 1'b1;
                pc_redirect     = 1'b1;
                redirect_pc     = INT_VECTOR;
                IF_Flush        = 1'b1;
                PC_write        = 1'b1;
                IF_ID_write     = 1'b1;
                ID_Flush_hazard = 1'b0;
                ID_Flush_branch = 1'b0;
                epc_d           = IF_PC;
                state_d         = StHandler;
            end
            StHandler: begin
                // An mret sitting behind a taken branch is wrong-path and must not return.
                if (ID_mret && !EX_branch_taken) begin
                    cnt_d    = CntW'(DRAIN_CYCLES - 1);
                    IF_Flush = 1'b1;
                    state_d  = StDrain;
                end
            end
            StDrain: begin
                PC_write = 1'b0;
                IF_Flush = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StRestore;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StRestore: begin
                INT_restore     = 1'b1;
                pc_redirect     = 1'b1;
                redirect_pc     = epc_q;
                IF_Flush        = 1'b1;
                PC_write        = 1'b1;
                IF_ID_write     = 1'b1;
                ID_Flush_hazard = 1'b0;
                ID_Flush_branch = 1'b0;
                state_d         = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
        end
    end

    assign in_handler = (state_q != StRun);
    assign epc        = epc_q;

endmodule

// File: tb/tb_pipe_hazard_int_ctrl.sv
// Directed bench: table of stall/flush vectors plus interrupt entry/return sequences.
module tb_pipe_hazard_int_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic [4:0]  EX_rd;
    logic        EX_mem_read;
    logic        EX_branch_taken;
    logic [31:0] IF_PC;
    logic        int_req;
    logic        int_en;
    logic        ID_mret;
    logic        PC_write;
    logic        IF_ID_write;
    logic        IF_Flush;
    logic        ID_Flush_hazard;
    logic        ID_Flush_branch;
    logic        INT_detected;
    logic        INT_restore;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        int_ack;
    logic        in_handler;
    logic [31:0] epc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mem_read;
        logic       br;
        logic       exp_pc_write;
        logic       exp_ifid_write;
        logic       exp_if_flush;
        logic       exp_fl_hz;
        logic       exp_fl_br;
    } vec_t;

    vec_t vecs[7];

    pipe_hazard_int_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .ID_rs1          (ID_rs1),
        .ID_rs2          (ID_rs2),
        .EX_rd           (EX_rd),
        .EX_mem_read     (EX_mem_read),
        .EX_branch_taken (EX_branch_taken),
        .IF_PC           (IF_PC),
        .int_req         (int_req),
        .int_en          (int_en),
        .ID_mret         (ID_mret),
        .PC_write        (PC_write),
        .IF_ID_write     (IF_ID_write),
        .IF_Flush        (IF_Flush),
        .ID_Flush_hazard (ID_Flush_hazard),
        .ID_Flush_branch (ID_Flush_branch),
        .INT_detected    (INT_detected),
        .INT_restore     (INT_restore),
        .pc_redirect     (pc_redirect),
        .redirect_pc     (redirect_pc),
        .int_ack         (int_ack),
        .in_handler      (in_handler),
        .epc             (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rs1   rs2   rd    mr    br    pcw   ifid  iff   fhz   fbr
        vecs[0] = '{5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        reset = 1'b1;
        ID_rs1 = '0; ID_rs2 = '0; EX_rd = '0; EX_mem_read = 1'b0; EX_branch_taken = 1'b0;
        IF_PC = '0; int_req = 1'b0; int_en = 1'b0; ID_mret = 1'b0;

        step();
        step();
        chk("rst_in_handler", in_handler, 0);
        chk("rst_epc", epc, 0);
        chk("rst_pc_write", PC_write, 1);
        chk("rst_ifid_write", IF_ID_write, 1);
        chk("rst_pc_redirect", pc_redirect, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_int_detected", INT_detected, 0);
        chk("rst_int_restore", INT_restore, 0);
        reset = 1'b0;

        // Combinational stall/flush table in RUN.
        for (int i = 0; i < 7; i++) begin
            step();
            ID_rs1 = vecs[i].rs1;
            ID_rs2 = vecs[i].rs2;
            EX_rd = vecs[i].rd;
            EX_mem_read = vecs[i].mem_read;
            EX_branch_taken = vecs[i].br;
            #1;
            chk($sformatf("vec%0d_pc_write", i), PC_write, vecs[i].exp_pc_write);
            chk($sformatf("vec%0d_ifid_write", i), IF_ID_write, vecs[i].exp_ifid_write);
            chk($sformatf("vec%0d_if_flush", i), IF_Flush, vecs[i].exp_if_flush);
            chk($sformatf("vec%0d_flush_hz", i), ID_Flush_hazard, vecs[i].exp_fl_hz);
            chk($sformatf("vec%0d_flush_br", i), ID_Flush_branch, vecs[i].exp_fl_br);
        end
        ID_rs1 = '0; ID_rs2 = '0; EX_rd = '0; EX_mem_read = 1'b0; EX_branch_taken = 1'b0;

        // Interrupt entry.
        step();
        IF_PC = 32'h40; int_req = 1'b1; int_en = 1'b1;
        #1;
        chk("run_in_handler", in_handler, 0);
        step();
        int_req = 1'b0;
        EX_branch_taken = 1'b1;
        #1;
        chk("enter_int_detected", INT_detected, 1);
        chk("enter_int_ack", int_ack, 1);
        chk("enter_pc_redirect", pc_redirect, 1);
        chk("enter_redirect_pc", redirect_pc, 32'h100);
        chk("enter_if_flush", IF_Flush, 1);
        chk("enter_flush_br", ID_Flush_branch, 0);
        chk("enter_int_restore", INT_restore, 0);
        chk("enter_in_handler", in_handler, 1);

        step();
        EX_branch_taken = 1'b0;
        IF_PC = 32'h200;
        int_req = 1'b1;
        EX_mem_read = 1'b1; EX_rd = 5'd7; ID_rs1 = 5'd7;
        #1;
        chk("hdl_epc", epc, 32'h40);
        chk("hdl_int_detected", INT_detected, 0);
        chk("hdl_int_ack", int_ack, 0);
        chk("hdl_in_handler", in_handler, 1);
        chk("hdl_pc_write_hz", PC_write, 0);
        chk("hdl_flush_hz", ID_Flush_hazard, 1);

        step();
        EX_mem_read = 1'b0;
        ID_mret = 1'b1;
        #1;
        chk("mret_no_nest", INT_detected, 0);
        chk("mret_if_flush", IF_Flush, 1);
        chk("mret_pc_redirect", pc_redirect, 0);

        step();
        ID_mret = 1'b0;
        for (int d = 0; d < 3; d++) begin
            if (d != 0) step();
            #1;
            chk($sformatf("drain%0d_pc_write", d), PC_write, 0);
            chk($sformatf("drain%0d_if_flush", d), IF_Flush, 1);
            chk($sformatf("drain%0d_int_restore", d), INT_restore, 0);
            chk($sformatf("drain%0d_in_handler", d), in_handler, 1);
        end

        step();
        EX_mem_read = 1'b1;
        #1;
        chk("rst_int_restore_pulse", INT_restore, 1);
        chk("rest_pc_redirect", pc_redirect, 1);
        chk("rest_redirect_pc", redirect_pc, 32'h40);
        chk("rest_if_flush", IF_Flush, 1);
        chk("rest_flush_hz", ID_Flush_hazard, 0);
        chk("rest_pc_write", PC_write, 1);
        chk("rest_int_detected", INT_detected, 0);
        EX_mem_read = 1'b0;

        // int_req held through RESTORE: one RUN cycle, then re-entry.
        step();
        #1;
        chk("ret_in_handler", in_handler, 0);
        chk("ret_int_restore", INT_restore, 0);
        chk("ret_int_detected", INT_detected, 0);
        step();
        #1;
        chk("reenter_int_detected", INT_detected, 1);
        int_req = 1'b0;

        // Reset in the middle of DRAIN.
        step();
        ID_mret = 1'b1;
        step();
        ID_mret = 1'b0;
        #1;
        chk("pre_rst_in_handler", in_handler, 1);
        reset = 1'b1;
        #1;
        chk("midrst_in_handler", in_handler, 0);
        chk("midrst_epc", epc, 0);
        chk("midrst_pc_write", PC_write, 1);
        chk("midrst_int_restore", INT_restore, 0);
        chk("midrst_if_flush", IF_Flush, 0);
        step();
        step();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("postrst%0d_int_restore", c), INT_restore, 0);
            chk($sformatf("postrst%0d_in_handler", c), in_handler, 0);
        end

        // int_en low: a pending request never enters.
        int_en = 1'b0;
        int_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("inten0_%0d_in_handler", c), in_handler, 0);
        end

        // Request deferred by a taken branch, taken once it clears.
        int_en = 1'b1;
        EX_branch_taken = 1'b1;
        step();
        chk("defer_in_handler", in_handler, 0);
        chk("defer_int_detected", INT_detected, 0);
        EX_branch_taken = 1'b0;
        step();
        chk("defer_enter_detected", INT_detected, 1);
        chk("defer_enter_ack", int_ack, 1);
        int_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
